usb_nrzi_rx: RTL and testbench

USB_NRZI_RX -- requirements
Module: usb_nrzi_rx

---
 rtl/usb_rx_pkg.sv | 35 +++
 rtl/usb_bit_sampler.sv | 77 +++++++
 rtl/usb_nrzi_rx.sv | 197 +++++++++++++++++++
 tb/tb_usb_nrzi_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// ---------------------------------------------------------------------------
// usb_rx_pkg
// Shared types and constants for the USB full/low-speed receive front end.
//   line_state_t : decoded differential line state, encoded as {D+, D-}
//   rx_state_t   : receiver FSM states
//   J_CODE/K_CODE: raw {D+, D-} encodings of the two data levels
// ---------------------------------------------------------------------------
package usb_rx_pkg;

    // Raw {D+, D-} encodings of the two data-carrying line levels.
    localparam logic [1:0] J_CODE   = 2'b10;
    localparam logic [1:0] K_CODE   = 2'b01;
    localparam logic [1:0] SE0_CODE = 2'b00;
    localparam logic [1:0] SE1_CODE = 2'b11;

    typedef enum logic [1:0] {
        LS_SE0 = SE0_CODE,
        LS_K   = K_CODE,
        LS_J   = J_CODE,
        LS_SE1 = SE1_CODE
    } line_state_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        EOP,
        ERR
    } rx_state_t;

    // True for the two line states that carry an NRZI data level.
    function automatic logic isDataLevel(input line_state_t ls);
        return (ls == LS_J) || (ls == LS_K);
    endfunction

endpackage

// File: rtl/usb_bit_sampler.sv
// ---------------------------------------------------------------------------
// usb_bit_sampler
// Registers the (already synchronous) D+/D- pair once and decides which
// clock cycles are bit sample points.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, loads the input register with J
//   enable_i  : receive enable; low holds the phase counter at zero
//   dp_i/dm_i : D+ / D- lines
//   line_o    : registered line state, used for all downstream decoding
//   sample_o  : high in cycles where line_o should be treated as a bit sample
// ---------------------------------------------------------------------------
module usb_bit_sampler
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        dp_i,
    input  logic        dm_i,
    output line_state_t line_o,
    output logic        sample_o
);

    line_state_t line_d;
    line_state_t line_q;

    assign line_d = line_state_t'({dp_i, dm_i});
    assign line_o = line_q;

    // Single input register; the idle line is J, so reset loads J.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= LS_J;
        end else begin
            line_q <= line_d;
        end
    end

    generate
        if (CLKS_PER_BIT <= 1) begin : gSingle
            // One clock per bit: every enabled cycle is a sample point.
            assign sample_o = enable_i;
        end else begin : gPhase
            localparam int PW = $clog2(CLKS_PER_BIT);
            localparam logic [PW-1:0] LAST_PHASE = PW'(CLKS_PER_BIT - 1);
            localparam logic [PW-1:0] MID_PHASE  = PW'(CLKS_PER_BIT / 2);

            logic [PW-1:0] phase_d;
            logic [PW-1:0] phase_q;

            // The counter is zero in the first cycle a new line state is
            // visible on line_q, so the sample lands mid-bit and re-locks on
            // every transition; it wraps so long runs sample once per bit.
            always_comb begin
                phase_d = phase_q + PW'(1);
                if (!enable_i || (line_d != line_q)) begin
                    phase_d = '0;
                end else if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            assign sample_o = enable_i && (phase_q == MID_PHASE);
        end
    endgenerate

endmodule

// File: rtl/usb_nrzi_rx.sv
// ---------------------------------------------------------------------------
// usb_nrzi_rx
// USB receive front end: samples the D+/D- pair, NRZI-decodes J/K levels,
// strips stuffed bits, detects end-of-packet and flags line errors.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (overrides enable)
//   enable     : receive enable; low forces IDLE and clears everything
//   dp_in      : D+ line, synchronous to clk
//   dm_in      : D- line, synchronous to clk
//   d_orig     : decoded data bit, meaningful while d_valid is high
//   d_valid    : one-cycle strobe per decoded, non-stuffed bit
//   stuff_bit  : one-cycle strobe per discarded stuffed bit
//   end_packet : one-cycle strobe on a valid EOP
//   error      : high while the receiver sits in ERR
//   busy       : high while a packet is being received (DATA or EOP)
// ---------------------------------------------------------------------------
module usb_nrzi_rx
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_BITS     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic dp_in,
    input  logic dm_in,
    output logic d_orig,
    output logic d_valid,
    output logic stuff_bit,
    output logic end_packet,
    output logic error,
    output logic busy
);

    localparam int OW = $clog2(STUFF_LEN + 2);
    localparam int EW = $clog2(EOP_BITS + 2);
    localparam logic [OW-1:0] STUFF_CNT = OW'(STUFF_LEN);
    localparam logic [EW-1:0] EOP_CNT   = EW'(EOP_BITS);
    // ERR exits on the (EOP_BITS+1)th consecutive J, i.e. when EOP_BITS
    // J samples have already been counted.
    localparam logic [EW-1:0] J_EXIT    = EW'(EOP_BITS);

    line_state_t sampledLine;
    logic        sampleStb;
    logic        decodedBit;

    rx_state_t   state_q;
    line_state_t prevLevel_q;
    logic [OW-1:0] onesCnt_q;
    logic [EW-1:0] se0Cnt_q;
    logic [EW-1:0] jRun_q;
    logic        dOrig_q;
    logic        dValid_q;
    logic        stuff_q;
    logic        eop_q;

    usb_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uSampler (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable),
        .dp_i     (dp_in),
        .dm_i     (dm_in),
        .line_o   (sampledLine),
        .sample_o (sampleStb)
    );

    // NRZI: no transition means 1, a transition means 0.
    assign decodedBit = (sampledLine == prevLevel_q);

    // Receiver FSM. All strobes are registered, so each appears exactly one
    // cycle after the sample that produced it. Disable behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_q     <= IDLE;
            prevLevel_q <= LS_J;
            onesCnt_q   <= '0;
            se0Cnt_q    <= '0;
            jRun_q      <= '0;
            dOrig_q     <= 1'b1;
            dValid_q    <= 1'b0;
            stuff_q     <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            dValid_q <= 1'b0;
            stuff_q  <= 1'b0;
            eop_q    <= 1'b0;

            if (sampleStb) begin
                // Stuffed bits still move the reference level.
                if (isDataLevel(sampledLine)) begin
                    prevLevel_q <= sampledLine;
                end

                case (state_q)
                    IDLE: begin
                        // The first K of the sync pattern opens the packet
                        // and is itself a decoded 0 (J -> K transition).
                        if (sampledLine == LS_K) begin
                            state_q   <= DATA;
                            dOrig_q   <= 1'b0;
                            dValid_q  <= 1'b1;
                            onesCnt_q <= '0;
                        end
                    end

                    DATA: begin
                        case (sampledLine)
                            LS_J, LS_K: begin
                                if (onesCnt_q == STUFF_CNT) begin
                                    // After a full run of 1s the next bit
                                    // must be a stuffed 0; a 1 is a violation.
                                    onesCnt_q <= '0;
                                    if (decodedBit) begin
                                        state_q <= ERR;
                                        jRun_q  <= '0;
                                    end else begin
                                        stuff_q <= 1'b1;
                                    end
                                end else begin
                                    dValid_q  <= 1'b1;
                                    dOrig_q   <= decodedBit;
                                    onesCnt_q <= decodedBit ? (onesCnt_q + OW'(1)) : '0;
                                end
                            end
                            LS_SE0: begin
                                state_q   <= EOP;
                                se0Cnt_q  <= EW'(1);
                                onesCnt_q <= '0;
                            end
                            default: begin
                                state_q   <= ERR;
                                onesCnt_q <= '0;
                                jRun_q    <= '0;
                            end
                        endcase
                    end

                    EOP: begin
                        case (sampledLine)
                            LS_SE0: begin
                                if (se0Cnt_q < EOP_CNT) begin
                                    se0Cnt_q <= se0Cnt_q + EW'(1);
                                end
                            end
                            LS_J: begin
                                se0Cnt_q <= '0;
                                if (se0Cnt_q >= EOP_CNT) begin
                                    eop_q   <= 1'b1;
                                    state_q <= IDLE;
                                end else begin
                                    state_q <= ERR;
                                    jRun_q  <= '0;
                                end
                            end
                            default: begin
                                se0Cnt_q <= '0;
                                state_q  <= ERR;
                                jRun_q   <= '0;
                            end
                        endcase
                    end

                    ERR: begin
                        // Recover only after a clean idle J run; any other
                        // sample restarts the run.
                        if (sampledLine == LS_J) begin
                            if (jRun_q == J_EXIT) begin
                                state_q <= IDLE;
                                jRun_q  <= '0;
                            end else begin
                                jRun_q <= jRun_q + EW'(1);
                            end
                        end else begin
                            jRun_q <= '0;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign d_orig     = dOrig_q;
    assign d_valid    = dValid_q;
    assign stuff_bit  = stuff_q;
    assign end_packet = eop_q;
    assign error      = (state_q == ERR);
    assign busy       = (state_q == DATA) || (state_q == EOP);

endmodule

// File: tb/tb_usb_nrzi_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_usb_nrzi_rx
// Scoreboard bench: each driven symbol pushes the strobe it should cause;
// negedge monitors pop and compare whenever a DUT raises a strobe.
// dut1 runs one clock per bit, dut4 runs four clocks per bit.
// ---------------------------------------------------------------------------
module tb_usb_nrzi_rx;

    typedef struct {
        logic [2:0] kind;    // {end_packet, stuff_bit, d_valid}
        logic       bitVal;
        int         cycle;   // -1 when timing is not checked
    } expT;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic dp1, dm1, dp4, dm4;
    logic dOrig1, dValid1, stuff1, eop1, error1, busy1;
    logic dOrig4, dValid4, stuff4, eop4, error4, busy4;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    expT q1[$];
    expT q4[$];
    expT got1;
    expT got4;

    usb_nrzi_rx #(.CLKS_PER_BIT(1), .STUFF_LEN(6), .EOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .dp_in(dp1), .dm_in(dm1),
        .d_orig(dOrig1), .d_valid(dValid1), .stuff_bit(stuff1),
        .end_packet(eop1), .error(error1), .busy(busy1)
    );

    usb_nrzi_rx #(.CLKS_PER_BIT(4), .STUFF_LEN(6), .EOP_BITS(2)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .dp_in(dp4), .dm_in(dm4),
        .d_orig(dOrig4), .d_valid(dValid4), .stuff_bit(stuff4),
        .end_packet(eop4), .error(error4), .busy(busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d",
                     tag, observed, expected, cyc);
        end
    endtask

    // Line symbols: J, K, 0 = SE0, anything else = SE1.
    task automatic setLine(input int sel, input byte c);
        logic [1:0] v;
        case (c)
            "J":     v = 2'b10;
            "K":     v = 2'b01;
            "0":     v = 2'b00;
            default: v = 2'b11;
        endcase
        if (sel == 0) {dp1, dm1} = v;
        else          {dp4, dm4} = v;
    endtask

    // Drives one symbol per bit time and pushes the strobe each symbol should
    // produce: '-' none, '0'/'1' data bit, 's' stuffed bit, 'e' end of packet.
    task automatic applyStimulus(input int sel, input string syms, input string exps,
                                 input int cps, input int shortIdx);
        expT e;
        for (int i = 0; i < syms.len(); i++) begin
            int hold;
            hold = (i == shortIdx) ? cps - 1 : cps;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                setLine(sel, syms[i]);
                if (k == 0 && exps[i] != "-") begin
                    e.kind   = (exps[i] == "s") ? 3'b010 :
                               (exps[i] == "e") ? 3'b100 : 3'b001;
                    e.bitVal = (exps[i] == "1");
                    e.cycle  = (sel == 0) ? cyc + 2 : -1;
                    if (sel == 0) q1.push_back(e);
                    else          q4.push_back(e);
                end
            end
        end
    endtask

    task automatic holdJ(input int sel, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            setLine(sel, "J");
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_dOrig"}, 32'(dOrig1), 32'd1);
        checkOutput({tag, "_dValid"}, 32'(dValid1), 32'd0);
        checkOutput({tag, "_stuff"}, 32'(stuff1), 32'd0);
        checkOutput({tag, "_eop"}, 32'(eop1), 32'd0);
        checkOutput({tag, "_error"}, 32'(error1), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy1), 32'd0);
    endtask

    // Scoreboard monitors: every strobe must match the next expectation.
    always @(negedge clk) begin
        if (dValid1 || stuff1 || eop1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1Unexpected", 32'({eop1, stuff1, dValid1}), 32'd0);
            end else begin
                got1 = q1.pop_front();
                checkOutput("dut1Kind", 32'({eop1, stuff1, dValid1}), 32'(got1.kind));
                if (got1.kind == 3'b001)
                    checkOutput("dut1Bit", 32'(dOrig1), 32'(got1.bitVal));
                checkOutput("dut1Cycle", 32'(cyc), 32'(got1.cycle));
            end
        end
    end

    always @(negedge clk) begin
        if (dValid4 || stuff4 || eop4) begin
            if (q4.size() == 0) begin
                checkOutput("dut4Unexpected", 32'({eop4, stuff4, dValid4}), 32'd0);
            end else begin
                got4 = q4.pop_front();
                checkOutput("dut4Kind", 32'({eop4, stuff4, dValid4}), 32'(got4.kind));
                if (got4.kind == 3'b001)
                    checkOutput("dut4Bit", 32'(dOrig4), 32'(got4.bitVal));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        setLine(0, "J");
        setLine(1, "J");
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        checkOutput("reset_dut4Busy", 32'(busy4), 32'd0);
        checkOutput("reset_dut4Error", 32'(error4), 32'd0);
        rst = 1'b0;

        // Basic decode followed by a clean EOP.
        applyStimulus(0, "JKKJKJJJK", "-01000110", 1, -1);
        checkOutput("pktBusy", 32'(busy1), 32'd1);
        applyStimulus(0, "00J", "--e", 1, -1);
        holdJ(0, 2);
        checkOutput("pktBusyAfter", 32'(busy1), 32'd0);
        checkOutput("pktError", 32'(error1), 32'd0);

        // Six 1s then a stuffed 0, then one more data bit and EOP.
        applyStimulus(0, "KKKKKKKJJ00JJ", "0111111s1--e-", 1, -1);
        holdJ(0, 2);
        checkOutput("stuffError", 32'(error1), 32'd0);
        checkOutput("stuffBusy", 32'(busy1), 32'd0);

        // Seventh 1 where a stuffed 0 belongs; recovery needs exactly 3 J.
        applyStimulus(0, "KKKKKKKK", "0111111-", 1, -1);
        holdJ(0, 2);
        checkOutput("stuffViolError", 32'(error1), 32'd1);
        checkOutput("stuffViolBusy", 32'(busy1), 32'd0);
        holdJ(0, 2);
        checkOutput("stuffViolStillErr", 32'(error1), 32'd1);
        holdJ(0, 1);
        checkOutput("stuffViolRecovered", 32'(error1), 32'd0);

        // EOP with too few SE0 bit times.
        applyStimulus(0, "KK0J", "01--", 1, -1);
        holdJ(0, 2);
        checkOutput("shortEopError", 32'(error1), 32'd1);
        holdJ(0, 5);
        checkOutput("shortEopRecovered", 32'(error1), 32'd0);

        // SE1 in the middle of a packet.
        applyStimulus(0, "KKS", "01-", 1, -1);
        holdJ(0, 2);
        checkOutput("se1Error", 32'(error1), 32'd1);
        holdJ(0, 2);
        checkOutput("se1StillErr", 32'(error1), 32'd1);
        holdJ(0, 1);
        checkOutput("se1Recovered", 32'(error1), 32'd0);
        checkOutput("se1Busy", 32'(busy1), 32'd0);

        // Reset mid-packet: the in-flight bit must not be reported.
        applyStimulus(0, "KJK", "000", 1, -1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        setLine(0, "J");
        @(posedge clk); #1;
        checkResetValues("midRst");
        rst = 1'b0;
        applyStimulus(0, "KKJ00J", "010--e", 1, -1);
        holdJ(0, 2);
        checkOutput("afterRstBusy", 32'(busy1), 32'd0);

        // Enable dropped mid-packet, with a K held while disabled.
        applyStimulus(0, "KJK", "000", 1, -1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        checkResetValues("midDis");
        setLine(0, "J");
        @(posedge clk); #1;
        checkResetValues("disHold");
        enable = 1'b1;
        applyStimulus(0, "KKJ00J", "010--e", 1, -1);
        holdJ(0, 2);
        checkOutput("afterDisBusy", 32'(busy1), 32'd0);

        // Four clocks per bit with one short (jittered) symbol.
        applyStimulus(1, "JKKJKJJJK00J", "-01000110--e", 4, 3);
        holdJ(1, 4);
        checkOutput("cpb4Error", 32'(error4), 32'd0);
        checkOutput("cpb4Busy", 32'(busy4), 32'd0);

        holdJ(0, 4);
        checkOutput("q1Drained", 32'(q1.size()), 32'd0);
        checkOutput("q4Drained", 32'(q4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
